// File: rtl/fixed_point_pkg.sv
// fixed_point: Q16.16 signed fixed-point type and its saturation limits
package fixed_point;

    typedef logic signed [31:0] fixed_point_t;

    localparam fixed_point_t FP_MAX = 32'sh7FFF_FFFF;
    localparam fixed_point_t FP_MIN = 32'sh8000_0000;

endpackage

// File: rtl/fixed_point_sub.sv
// fixed_point_sub: wrapped Q16.16 subtraction a - b with signed overflow flag
module fixed_point_sub
    import fixed_point::*;
(
    input  fixed_point_t a,
    input  fixed_point_t b,
    output fixed_point_t diff,
    output logic         ovf
);

    assign diff = a - b;
    // Overflow: operands of opposite sign and the result took the subtrahend's sign.
    assign ovf  = (a[31] != b[31]) && (diff[31] == b[31]);

endmodule

// File: rtl/edge_delta_stage.sv
// edge_delta_stage: two-stage valid/ready pipeline computing edge deltas dx/dy with overflow tracking
module edge_delta_stage
    import fixed_point::*;
#(
    parameter int SATURATE = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  fixed_point_t     x0,
    input  fixed_point_t     y0,
    input  fixed_point_t     x1,
    input  fixed_point_t     y1,
    output logic             out_valid,
    input  logic             out_ready,
    output fixed_point_t     dx,
    output fixed_point_t     dy,
    output logic             dx_ovf,
    output logic             dy_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    logic         s1_valid;
    logic         s1_adv;
    fixed_point_t s1_x0, s1_y0, s1_x1, s1_y1;
    fixed_point_t dx_raw, dy_raw, dx_res, dy_res;
    logic         dx_of, dy_of;

    assign s1_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;

    fixed_point_sub u_sub_x (.a(s1_x1), .b(s1_x0), .diff(dx_raw), .ovf(dx_of));
    fixed_point_sub u_sub_y (.a(s1_y1), .b(s1_y0), .diff(dy_raw), .ovf(dy_of));

    // Clamp toward the sign of the minuend when saturating; otherwise keep the wrapped value.
    assign dx_res = (SATURATE != 0 && dx_of) ? (s1_x1[31] ? FP_MIN : FP_MAX) : dx_raw;
    assign dy_res = (SATURATE != 0 && dy_of) ? (s1_y1[31] ? FP_MIN : FP_MAX) : dy_raw;

    // S1: capture the vertex pair whenever the stage is free or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x0    <= '0;
            s1_y0    <= '0;
            s1_x1    <= '0;
            s1_y1    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x0 <= x0;
                s1_y0 <= y0;
                s1_x1 <= x1;
                s1_y1 <= y1;
            end
        end
    end

    // S2: register the deltas and flags; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            dx_ovf    <= 1'b0;
            dy_ovf    <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                dx     <= dx_res;
                dy     <= dy_res;
                dx_ovf <= dx_of;
                dy_ovf <= dy_of;
            end
        end
    end

    // Overflow bookkeeping on the output handshake; a clear wins over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (out_valid && out_ready && (dx_ovf || dy_ovf)) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != {CNT_W{1'b1}})
                ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_edge_delta_stage.sv
// tb_edge_delta_stage: scoreboard bench for edge_delta_stage, saturating and wrapping variants side by side
module tb_edge_delta_stage;

    localparam int CNT_W = 8;
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] sat;
        logic [31:0] wrap;
        logic        ovf;
    } dres_t;

    typedef struct {
        dres_t x;
        dres_t y;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic             ovf_clr = 1'b0;
    logic [31:0]      x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic             in_ready, in_ready_w;
    logic             ov_s, ov_w;
    logic [31:0]      dx_s, dy_s, dx_w, dy_w;
    logic             dxo_s, dyo_s, dxo_w, dyo_w;
    logic             st_s, st_w;
    logic [CNT_W-1:0] cnt_s, cnt_w;

    int    n_vec = 0;
    int    n_bad = 0;
    int    hold_low = 0;
    bit    bp_en = 1'b0;
    bit    saw_block = 1'b0;
    int    cnt_m = 0;
    bit    sticky_m = 1'b0;
    bit    hs_ovf;
    exp_t  q[$];
    exp_t  e;

    edge_delta_stage #(.SATURATE(1), .CNT_W(CNT_W)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .out_valid(ov_s), .out_ready(out_ready), .dx(dx_s), .dy(dy_s),
        .dx_ovf(dxo_s), .dy_ovf(dyo_s), .ovf_sticky(st_s), .ovf_count(cnt_s), .ovf_clr(ovf_clr)
    );

    edge_delta_stage #(.SATURATE(0), .CNT_W(CNT_W)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .out_valid(ov_w), .out_ready(out_ready), .dx(dx_w), .dy(dy_w),
        .dx_ovf(dxo_w), .dy_ovf(dyo_w), .ovf_sticky(st_w), .ovf_count(cnt_w), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Exact difference in wide arithmetic; overflow means it does not fit in 32 signed bits.
    function automatic dres_t delta(logic [31:0] op1, logic [31:0] op0);
        longint d;
        dres_t  r;
        d      = longint'($signed(op1)) - longint'($signed(op0));
        r.wrap = d[31:0];
        r.ovf  = (d > LMAX) || (d < LMIN);
        r.sat  = r.ovf ? ((d > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : r.wrap;
        return r;
    endfunction

    function automatic logic [31:0] rnd_val();
        int k;
        k = $urandom_range(0, 3);
        return (k == 0) ? $urandom() :
               (k == 1) ? (32'h7FF0_0000 | 32'($urandom_range(0, 32'hF_FFFF))) :
               (k == 2) ? (32'h8000_0000 | 32'($urandom_range(0, 32'hF_FFFF))) :
                          32'($urandom_range(0, 32'h3_FFFF)) - 32'h2_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Presents a pair and waits (bounded) until it is taken; returns just after the accepting edge.
    task automatic send(input logic [31:0] a1, input logic [31:0] a0,
                        input logic [31:0] b1, input logic [31:0] b0);
        bit done;
        done = 1'b0;
        x1 = a1; x0 = a0; y1 = b1; y0 = b0;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{x: delta(a1, a0), y: delta(b1, b0)});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_empty", 64'(q.size()), 0);
    endtask

    // Downstream: forced stall window, optional random backpressure, otherwise always ready.
    initial forever begin
        @(posedge clk);
        #1;
        if (hold_low > 0) begin
            out_ready = 1'b0;
            hold_low--;
        end else begin
            out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each output handshake and tracks the overflow counter.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
            sticky_m = 1'b0;
            chk("rst_out_valid", {63'd0, ov_s | ov_w}, 0);
            chk("rst_in_ready", {62'd0, in_ready, in_ready_w}, 64'd3);
            chk("rst_dx_dy", {dx_s, dy_s}, 0);
            chk("rst_flags", {58'd0, dxo_s, dyo_s, dxo_w, dyo_w, st_s, st_w}, 0);
            chk("rst_count", {48'd0, cnt_s, cnt_w}, 0);
        end else begin
            chk("ovf_count", {48'd0, cnt_s, cnt_w}, {48'd0, 8'(cnt_m), 8'(cnt_m)});
            chk("ovf_sticky", {62'd0, st_s, st_w}, {62'd0, sticky_m, sticky_m});
            if (in_valid && !in_ready) saw_block = 1'b1;
            hs_ovf = 1'b0;
            if (ov_s && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("dx_sat", {32'd0, dx_s}, {32'd0, e.x.sat});
                    chk("dy_sat", {32'd0, dy_s}, {32'd0, e.y.sat});
                    chk("dx_wrap", {32'd0, dx_w}, {32'd0, e.x.wrap});
                    chk("dy_wrap", {32'd0, dy_w}, {32'd0, e.y.wrap});
                    chk("ovf_flags", {60'd0, dxo_s, dyo_s, dxo_w, dyo_w},
                        {60'd0, e.x.ovf, e.y.ovf, e.x.ovf, e.y.ovf});
                    chk("wrap_valid", {63'd0, ov_w}, 1);
                    hs_ovf = e.x.ovf || e.y.ovf;
                end
            end
            if (ovf_clr) begin
                cnt_m = 0;
                sticky_m = 1'b0;
            end else if (hs_ovf) begin
                sticky_m = 1'b1;
                cnt_m = (cnt_m < 255) ? cnt_m + 1 : cnt_m;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic delta and two-cycle latency.
        send(32'h0003_0000, 32'h0001_8000, 32'h0000_0000, 32'h0001_0000);
        in_valid = 1'b0;
        chk("latency_c1", {63'd0, ov_s}, 0);
        @(posedge clk); #1;
        chk("latency_c2", {63'd0, ov_s}, 1);
        chk("basic_dx", {32'd0, dx_s}, 64'h0001_8000);
        chk("basic_dy", {32'd0, dy_s}, 64'hFFFF_0000);
        chk("basic_flags", {62'd0, dxo_s, dyo_s}, 0);
        drain();

        // Positive overflow: clamp vs wrap, counter increments once.
        send(32'h7FFF_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("ovf_dx_flag", {63'd0, dxo_s}, 1);
        chk("ovf_dx_sat", {32'd0, dx_s}, 64'h7FFF_FFFF);
        chk("ovf_dx_wrap", {32'd0, dx_w}, 64'h8000_0000);
        @(posedge clk); #1;
        chk("ovf_count_one", {56'd0, cnt_s}, 1);

        // Stream of 10 with a 3-cycle stall mid-stream.
        saw_block = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) hold_low = 3;
            send(rnd_val(), rnd_val(), rnd_val(), rnd_val());
        end
        drain();
        chk("stall_in_ready_low", {63'd0, saw_block}, 1);

        // Counter saturation, then a clear coincident with an overflow handshake.
        for (int i = 0; i < 300; i++) send(32'h7FFF_0000, 32'hFFFF_0000, 32'h8000_0000, 32'h0001_0000);
        drain();
        chk("ovf_count_sat", {56'd0, cnt_s}, 255);
        send(32'h7FFF_0000, 32'hFFFF_0000, 32'h0, 32'h0);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !ov_s; k++) begin
            @(posedge clk); #1;
        end
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("clr_priority_count", {56'd0, cnt_s}, 0);
        chk("clr_priority_sticky", {63'd0, st_s}, 0);

        // Random traffic with backpressure and occasional clears.
        bp_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ovf_clr = ($urandom_range(0, 15) == 0);
            send(rnd_val(), rnd_val(), rnd_val(), rnd_val());
        end
        ovf_clr = 1'b0;
        drain();
        bp_en = 1'b0;

        // Reset with both stages full.
        hold_low = 50;
        send(32'h0001_0000, 32'h0, 32'h0002_0000, 32'h0);
        send(32'h0003_0000, 32'h0, 32'h0004_0000, 32'h0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("full_out_valid", {63'd0, ov_s}, 1);
        chk("full_in_ready", {63'd0, in_ready}, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", {62'd0, ov_s, ov_w}, 0);
        @(posedge clk); #1;
        hold_low = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 1);
        send(32'h0000_8000, 32'h0001_0000, 32'hFFFF_0000, 32'h7FFF_0000);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
